lfsr_seq_gen: RTL

Parametrised successor to the 3-bit hand-wired next-state machine: a WIDTH-bit feedback shift-register sequencer with selectable Fibonacci/Galois feedback, a seed-load handshake, lock-up recovery and period measurement. It sits in the sequential-logic activities as the reusable state-sequence source, with a single-bit decoded output `y` as in the earlier machine.

---
 rtl/lfsr_pkg.sv | 12 +
 rtl/lfsr_seq_gen_if.sv | 27 ++
 rtl/lfsr_next.sv | 19 +
 rtl/lfsr_seq_gen.sv | 91 +++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and elaboration bounds for the feedback shift-register sequencer.
package lfsr_pkg;

  typedef enum logic {
    MODE_FIB = 1'b0,
    MODE_GAL = 1'b1
  } lfsr_mode_t;

  localparam int LFSR_WIDTH_MIN = 3;
  localparam int LFSR_WIDTH_MAX = 32;

endpackage

// File: rtl/lfsr_seq_gen_if.sv
// Control/observation bundle for lfsr_seq_gen: step/mode inputs, seed-load handshake, status outputs.
interface lfsr_seq_gen_if #(
  parameter int WIDTH = 8
) ();

  logic             en;
  logic             mode;
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic [WIDTH-1:0] state;
  logic             y;
  logic [WIDTH-1:0] period;
  logic             wrap;
  logic             recovered;

  modport master (
    output en, mode, load_valid, load_data,
    input  load_ready, state, y, period, wrap, recovered
  );

  modport slave (
    input  en, mode, load_valid, load_data,
    output load_ready, state, y, period, wrap, recovered
  );

endinterface

// File: rtl/lfsr_next.sv
// Combinational next-state function: Fibonacci (XOR taps into LSB) or Galois (conditional polynomial XOR).
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8
) (
  input  logic [WIDTH-1:0] state,
  input  lfsr_mode_t       mode,
  output logic [WIDTH-1:0] next
);

  always_comb begin
    next = {state[WIDTH-2:0], ^(state & TAPS)};
    if (mode == MODE_GAL)
      next = {state[WIDTH-2:0], 1'b0} ^ (state[WIDTH-1] ? TAPS : '0);
  end

endmodule

// File: rtl/lfsr_seq_gen.sv
// WIDTH-bit LFSR sequencer with seed-load handshake, lock-up recovery and period measurement.
module lfsr_seq_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] TAPS     = 8'hB8,
  parameter logic [WIDTH-1:0] SEED     = 8'h01,
  parameter logic [WIDTH-1:0] OUT_MASK = 8'h03
) (
  input  logic          clk,
  input  logic          reset_n,
  lfsr_seq_gen_if.slave bus
);

  if (WIDTH < LFSR_WIDTH_MIN || WIDTH > LFSR_WIDTH_MAX) begin : g_bad_width
    $error("lfsr_seq_gen: WIDTH out of range");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_seq_gen: SEED must be non-zero");
  end

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] state_q, seed_q, step_cnt, period_q, next_state;
  logic             wrap_q, recovered_q, load_ready_q, settle_q;
  logic             accept, cnt_sat, hit_seed;

  lfsr_next #(.WIDTH(WIDTH), .TAPS(TAPS)) u_next (
    .state (state_q),
    .mode  (lfsr_mode_t'(bus.mode)),
    .next  (next_state)
  );

  assign accept   = bus.load_valid && load_ready_q;
  assign cnt_sat  = &step_cnt;
  // A saturated counter means the measurement is meaningless, so the wrap is suppressed.
  assign hit_seed = (next_state == seed_q) && !cnt_sat;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= SEED;
      seed_q       <= SEED;
      step_cnt     <= '0;
      period_q     <= '0;
      wrap_q       <= 1'b0;
      recovered_q  <= 1'b0;
      load_ready_q <= 1'b0;
      settle_q     <= 1'b0;
    end else begin
      wrap_q       <= 1'b0;
      recovered_q  <= 1'b0;
      load_ready_q <= !accept;
      settle_q     <= accept;
      if (accept) begin
        step_cnt <= '0;
        if (bus.load_data == '0) begin
          state_q     <= SEED;
          seed_q      <= SEED;
          recovered_q <= 1'b1;
        end else begin
          state_q <= bus.load_data;
          seed_q  <= bus.load_data;
        end
      end else if (!settle_q && bus.en) begin
        if (state_q == '0) begin
          state_q     <= SEED;
          seed_q      <= SEED;
          step_cnt    <= '0;
          recovered_q <= 1'b1;
        end else begin
          state_q <= next_state;
          if (hit_seed) begin
            period_q <= step_cnt + ONE;
            step_cnt <= '0;
            wrap_q   <= 1'b1;
          end else if (!cnt_sat) begin
            step_cnt <= step_cnt + ONE;
          end
        end
      end
    end
  end

  assign bus.state      = state_q;
  assign bus.y          = |(state_q & OUT_MASK);
  assign bus.period     = period_q;
  assign bus.wrap       = wrap_q;
  assign bus.recovered  = recovered_q;
  assign bus.load_ready = load_ready_q;

endmodule
